// File: rtl/spi_rib_bridge.sv
// SPI-slave (mode 0, MSB first) to RIB-master bridge: command byte, 32-bit
// big-endian address, then burst write words in or burst read words out.
module spi_rib_bridge #(
   parameter int         SYNC_STAGES = 2,
   parameter int         ACC_CYCLES  = 2,
   parameter logic [7:0] CMD_WRITE   = 8'h02,
   parameter logic [7:0] CMD_READ    = 8'h03
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        spi_sclk,
   input  logic        spi_ss,
   input  logic        spi_mosi,
   output logic        spi_miso,
   output logic        spi_miso_oe,
   output logic        req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic [31:0] mem_rdata_i
);

   localparam int                ACC_W    = $clog2(ACC_CYCLES + 1);
   localparam logic [ACC_W-1:0] ACC_LAST = ACC_W'(ACC_CYCLES - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_CMD, S_ADDR, S_WDATA, S_WR_BUS, S_RD_BUS, S_DUMMY, S_RDATA, S_IGNORE
   } state_e;

   state_e                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
   logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
   logic                   sclk_prev_q, sclk_prev_d;
   logic [5:0]             bit_cnt_q, bit_cnt_d;
   logic [31:0]            shift_q, shift_d;
   logic [31:0]            tx_q, tx_d;
   logic [31:0]            rbuf_q, rbuf_d;
   logic [31:0]            addr_q, addr_d;
   logic [31:0]            wdata_q, wdata_d;
   logic                   we_q, we_d;
   logic                   req_q, req_d;
   logic                   first_q, first_d;
   logic [ACC_W-1:0]       acc_q, acc_d;

   logic        sclk_s, ss_s, mosi_s, sclk_rise, sclk_fall;
   logic [31:0] rx_word;

   assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign ss_s      = ss_sync_q[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_prev_q;
   assign sclk_fall = ~sclk_s & sclk_prev_q;
   assign rx_word   = {shift_q[30:0], mosi_s};

   assign spi_miso    = tx_q[31];
   assign spi_miso_oe = ~ss_s;
   assign req_o       = req_q;
   assign mem_we_o    = we_q;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;

   always_comb begin
      sclk_sync_d    = sclk_sync_q << 1;
      sclk_sync_d[0] = spi_sclk;
      ss_sync_d      = ss_sync_q << 1;
      ss_sync_d[0]   = spi_ss;
      mosi_sync_d    = mosi_sync_q << 1;
      mosi_sync_d[0] = spi_mosi;
      sclk_prev_d    = sclk_s;
   end

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      tx_d      = tx_q;
      rbuf_d    = rbuf_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      we_d      = we_q;
      req_d     = req_q;
      first_d   = first_q;
      acc_d     = acc_q;
      // Deselect outside a bus access drops everything received so far.
      if (ss_s && state_q != S_IDLE && state_q != S_WR_BUS && state_q != S_RD_BUS) begin
         state_d   = S_IDLE;
         bit_cnt_d = '0;
         shift_d   = '0;
         tx_d      = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               bit_cnt_d = '0;
               shift_d   = '0;
               tx_d      = '0;
               if (!ss_s) state_d = S_CMD;
            end
            S_CMD: if (sclk_rise) begin
               shift_d   = rx_word;
               bit_cnt_d = bit_cnt_q + 6'd1;
               if (bit_cnt_q == 6'd7) begin
                  bit_cnt_d = '0;
                  shift_d   = '0;
                  if (rx_word[7:0] == CMD_WRITE) begin
                     state_d = S_ADDR;
                     we_d    = 1'b1;
                  end else if (rx_word[7:0] == CMD_READ) begin
                     state_d = S_ADDR;
                     we_d    = 1'b0;
                  end else begin
                     state_d = S_IGNORE;
                  end
               end
            end
            S_ADDR: if (sclk_rise) begin
               shift_d   = rx_word;
               bit_cnt_d = bit_cnt_q + 6'd1;
               if (bit_cnt_q == 6'd31) begin
                  bit_cnt_d = '0;
                  shift_d   = '0;
                  addr_d    = {rx_word[31:2], 2'b00};
                  if (we_q) begin
                     state_d = S_WDATA;
                  end else begin
                     state_d = S_RD_BUS;
                     req_d   = 1'b1;
                     acc_d   = '0;
                     first_d = 1'b1;
                  end
               end
            end
            S_WDATA: if (sclk_rise) begin
               shift_d   = rx_word;
               bit_cnt_d = bit_cnt_q + 6'd1;
               if (bit_cnt_q == 6'd31) begin
                  bit_cnt_d = '0;
                  shift_d   = '0;
                  wdata_d   = rx_word;
                  state_d   = S_WR_BUS;
                  req_d     = 1'b1;
                  acc_d     = '0;
               end
            end
            S_WR_BUS: begin
               acc_d = acc_q + 1'b1;
               if (acc_q == ACC_LAST) begin
                  req_d   = 1'b0;
                  addr_d  = addr_q + 32'd4;
                  state_d = ss_s ? S_IDLE : S_WDATA;
               end
            end
            S_RD_BUS: begin
               acc_d = acc_q + 1'b1;
               if (acc_q == ACC_LAST) begin
                  req_d   = 1'b0;
                  rbuf_d  = mem_rdata_i;
                  addr_d  = addr_q + 32'd4;
                  first_d = 1'b0;
                  if (ss_s) begin
                     state_d = S_IDLE;
                     tx_d    = '0;
                  end else begin
                     state_d = first_q ? S_DUMMY : S_RDATA;
                  end
               end
            end
            S_DUMMY: begin
               if (sclk_rise && bit_cnt_q < 6'd8) bit_cnt_d = bit_cnt_q + 6'd1;
               // The falling edge closing the dummy byte presents the first word.
               if (sclk_fall && bit_cnt_q == 6'd8) begin
                  tx_d      = rbuf_q;
                  bit_cnt_d = '0;
                  state_d   = S_RD_BUS;
                  req_d     = 1'b1;
                  acc_d     = '0;
               end
            end
            S_RDATA: begin
               if (sclk_rise) bit_cnt_d = bit_cnt_q + 6'd1;
               if (sclk_fall) begin
                  if (bit_cnt_q == 6'd32) begin
                     tx_d      = rbuf_q;
                     bit_cnt_d = '0;
                     state_d   = S_RD_BUS;
                     req_d     = 1'b1;
                     acc_d     = '0;
                  end else begin
                     tx_d = tx_q << 1;
                  end
               end
            end
            S_IGNORE: ;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         sclk_sync_q <= '0;
         ss_sync_q   <= '1;
         mosi_sync_q <= '0;
         sclk_prev_q <= 1'b0;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         tx_q        <= '0;
         rbuf_q      <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         we_q        <= 1'b0;
         req_q       <= 1'b0;
         first_q     <= 1'b0;
         acc_q       <= '0;
      end else begin
         state_q     <= state_d;
         sclk_sync_q <= sclk_sync_d;
         ss_sync_q   <= ss_sync_d;
         mosi_sync_q <= mosi_sync_d;
         sclk_prev_q <= sclk_prev_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         tx_q        <= tx_d;
         rbuf_q      <= rbuf_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         we_q        <= we_d;
         req_q       <= req_d;
         first_q     <= first_d;
         acc_q       <= acc_d;
      end
   end

endmodule

// File: tb/tb_spi_rib_bridge.sv
// Bench for spi_rib_bridge: an SPI master driver, a RIB memory model and a
// frame-level reference of the expected bus accesses and MISO bytes.
module tb_spi_rib_bridge;

   localparam int         ACC    = 2;
   localparam int         HALF   = 50;
   localparam logic [7:0] CMD_WR = 8'h02;
   localparam logic [7:0] CMD_RD = 8'h03;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
   } acc_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        spi_sclk = 1'b0, spi_ss = 1'b1, spi_mosi = 1'b0;
   logic        spi_miso, spi_miso_oe, req_o, mem_we_o;
   logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

   int   n_chk = 0, n_err = 0;
   acc_t exp_q[$], obs_q[$];
   acc_t cur;
   int   run = 0;
   logic [7:0]  txb[0:63], rxb[0:63], erx[0:63];
   logic [31:0] wd[0:3];

   always #5 clk = ~clk;

   spi_rib_bridge dut (
      .clk(clk), .rst(rst),
      .spi_sclk(spi_sclk), .spi_ss(spi_ss), .spi_mosi(spi_mosi),
      .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
      .req_o(req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
   );

   function automatic logic [31:0] mem_val(input logic [31:0] a);
      if (a == 32'h3000) return 32'hCAFE_F00D;
      if (a == 32'h3004) return 32'h0102_0304;
      return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   assign mem_rdata_i = mem_val(mem_addr_o);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
      end
   endtask

   // Bus monitor: every request must be a clean ACC-cycle pulse with stable controls.
   always @(negedge clk) begin
      if (!rst) run = 0;
      else if (req_o) begin
         if (run == 0) begin
            cur.we = mem_we_o; cur.addr = mem_addr_o; cur.data = mem_wdata_o;
         end else begin
            chk("req_addr_stable", mem_addr_o, cur.addr);
            chk("req_we_stable", mem_we_o, cur.we);
            chk("req_wdata_stable", mem_wdata_o, cur.data);
         end
         run++;
      end else if (run > 0) begin
         chk("req_len", run, ACC);
         obs_q.push_back(cur);
         run = 0;
      end
   end

   // Mode-0 master; the last SCLK fall coincides with SS release.
   task automatic spi_frame(input int n);
      logic oe_ok;
      oe_ok = 1'b1;
      @(posedge clk); #2;
      spi_ss = 1'b0;
      for (int b = 0; b < n; b++) begin
         for (int k = 7; k >= 0; k--) begin
            spi_mosi = txb[b][k];
            #HALF;
            rxb[b][k] = spi_miso;
            if (!spi_miso_oe) oe_ok = 1'b0;
            spi_sclk = 1'b1;
            #HALF;
            spi_sclk = 1'b0;
            if (b == n - 1 && k == 0) spi_ss = 1'b1;
         end
      end
      spi_mosi = 1'b0;
      chk("oe_in_frame", oe_ok, 1'b1);
   endtask

   task automatic run_frame(input logic [7:0] cmd, input logic [31:0] a, input int nw,
                            input int part);
      int          n;
      logic [31:0] ab, w;
      acc_t        e;
      n  = 0;
      ab = {a[31:2], 2'b00};
      txb[n] = cmd; erx[n] = 8'h00; n++;
      for (int i = 3; i >= 0; i--) begin txb[n] = a[8*i +: 8]; erx[n] = 8'h00; n++; end
      if (cmd == CMD_RD) begin
         txb[n] = 8'($urandom); erx[n] = 8'h00; n++;
         for (int i = 0; i < nw; i++) begin
            w = mem_val(ab + 32'(4 * i));
            for (int j = 3; j >= 0; j--) begin txb[n] = 8'($urandom); erx[n] = w[8*j +: 8]; n++; end
         end
         // Each word presented launches the next read, so nw words cost nw+1 reads.
         for (int i = 0; i <= nw; i++) begin
            e.we = 1'b0; e.addr = ab + 32'(4 * i); e.data = '0; exp_q.push_back(e);
         end
      end else if (cmd == CMD_WR) begin
         for (int i = 0; i < nw; i++) begin
            w = wd[i];
            for (int j = 3; j >= 0; j--) begin txb[n] = w[8*j +: 8]; erx[n] = 8'h00; n++; end
            e.we = 1'b1; e.addr = ab + 32'(4 * i); e.data = w; exp_q.push_back(e);
         end
         for (int i = 0; i < part; i++) begin txb[n] = 8'($urandom); erx[n] = 8'h00; n++; end
      end else begin
         for (int i = 0; i < 4 * nw; i++) begin txb[n] = 8'($urandom); erx[n] = 8'h00; n++; end
      end
      spi_frame(n);
      repeat (20) @(posedge clk);
      #2;
      chk("acc_count", obs_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         chk("acc_addr", obs_q[i].addr, exp_q[i].addr);
         chk("acc_we", obs_q[i].we, exp_q[i].we);
         if (exp_q[i].we) chk("acc_wdata", obs_q[i].data, exp_q[i].data);
      end
      for (int b = 0; b < n; b++) chk("miso_byte", rxb[b], erx[b]);
      chk("idle_oe", spi_miso_oe, 1'b0);
      chk("idle_miso", spi_miso, 1'b0);
      exp_q.delete();
      obs_q.delete();
   endtask

   initial begin
      logic [31:0] a;
      int          w;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_req", req_o, 1'b0);
      chk("rst_we", mem_we_o, 1'b0);
      chk("rst_addr", mem_addr_o, 32'h0);
      chk("rst_wdata", mem_wdata_o, 32'h0);
      chk("rst_miso", spi_miso, 1'b0);
      chk("rst_oe", spi_miso_oe, 1'b0);
      rst = 1'b1;
      repeat (5) @(posedge clk);

      wd[0] = 32'hDEAD_BEEF;
      run_frame(CMD_WR, 32'h0000_1000, 1, 0);
      wd[0] = 32'h1122_3344; wd[1] = 32'h5566_7788;
      run_frame(CMD_WR, 32'h0000_2000, 2, 0);
      run_frame(CMD_RD, 32'h0000_3000, 2, 0);
      run_frame(8'h5A, $urandom, 1, 0);
      run_frame(CMD_WR, 32'h0000_4000, 0, 2);
      wd[0] = 32'hA5A5_A5A5;
      run_frame(CMD_WR, 32'h0000_5000, 1, 0);
      run_frame(CMD_RD, 32'hFFFF_FFFE, 2, 0);

      // Reset landing in the second request cycle of a write.
      txb[0] = CMD_WR; txb[1] = 8'h00; txb[2] = 8'h00; txb[3] = 8'h60; txb[4] = 8'h00;
      txb[5] = 8'h12; txb[6] = 8'h34; txb[7] = 8'h56; txb[8] = 8'h78;
      fork
         spi_frame(9);
         begin
            w = 0;
            while (!req_o && w < 2000) begin @(negedge clk); w++; end
            chk("rst_req_seen", req_o, 1'b1);
            @(posedge clk); #2;
            rst = 1'b0;
            #1;
            chk("arst_req", req_o, 1'b0);
            chk("arst_we", mem_we_o, 1'b0);
            chk("arst_addr", mem_addr_o, 32'h0);
            chk("arst_wdata", mem_wdata_o, 32'h0);
            chk("arst_miso", spi_miso, 1'b0);
            chk("arst_oe", spi_miso_oe, 1'b0);
            repeat (3) @(posedge clk);
            #2 rst = 1'b1;
         end
      join
      repeat (20) @(posedge clk);
      chk("arst_no_acc", obs_q.size(), 0);
      obs_q.delete();
      wd[0] = 32'h0BAD_F00D;
      run_frame(CMD_WR, 32'h0000_7000, 1, 0);

      for (int it = 0; it < 9; it++) begin
         logic [7:0] c;
         int         nw;
         a  = $urandom;
         if (it % 3 == 0) a[31:4] = 28'hFFF_FFFF;
         nw = $urandom_range(1, 3);
         for (int i = 0; i < 4; i++) wd[i] = $urandom;
         case (it % 3)
            0: run_frame(CMD_RD, a, nw, 0);
            1: run_frame(CMD_WR, a, nw, $urandom_range(0, 3));
            default: begin
               c = 8'($urandom);
               if (c == CMD_WR || c == CMD_RD) c = 8'hA5;
               run_frame(c, a, nw, 0);
            end
         endcase
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
